// File: rtl/snake_draw_sequencer_if.sv
// Single-pixel write port shared by all draw requesters and consumed by vga_adapter.
`timescale 1ns/1ps
interface snake_draw_sequencer_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    modport master (output vga_x, vga_y, vga_colour, plot);
    modport slave  (input  vga_x, vga_y, vga_colour, plot);
endinterface

// File: rtl/snake_draw_sequencer.sv
// Per-tick scheduler: walks the tail-erase, head and apple blocks in fixed order
// over the one vga_adapter port, clipping pixels that fall off screen.
`timescale 1ns/1ps
module snake_draw_sequencer #(
    parameter int         XDIM      = 10,
    parameter int         YDIM      = 10,
    parameter int         XSCREEN   = 160,
    parameter int         YSCREEN   = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                          CLOCK_50,
    input  logic                          Resetn,
    input  logic                          tick,
    input  logic [7:0]                    head_x,
    input  logic [6:0]                    head_y,
    input  logic [2:0]                    head_colour,
    input  logic [7:0]                    tail_x,
    input  logic [6:0]                    tail_y,
    input  logic                          tail_valid,
    input  logic                          apple_req,
    input  logic [7:0]                    apple_x,
    input  logic [6:0]                    apple_y,
    input  logic [2:0]                    apple_colour,
    snake_draw_sequencer_if.master        vga,
    output logic                          busy,
    output logic                          done,
    output logic                          apple_pending
);

    localparam int XW = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int YW = (YDIM > 1) ? $clog2(YDIM) : 1;

    typedef enum logic [2:0] {IDLE, ERASE, HEAD, APPLE, DONE} state_t;

    state_t          state, state_nx;
    logic [XW-1:0]   xc;
    logic [YW-1:0]   yc;
    logic [7:0]      head_x_q, tail_x_q, apple_x_q;
    logic [6:0]      head_y_q, tail_y_q, apple_y_q;
    logic [2:0]      head_colour_q, apple_colour_q;
    logic            do_apple;

    logic            accept, drawing, x_end, last_px;
    logic [7:0]      base_x;
    logic [6:0]      base_y;
    logic [2:0]      colour;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;

    assign accept  = (state == IDLE) && tick;
    assign drawing = (state == ERASE) || (state == HEAD) || (state == APPLE);
    assign x_end   = (xc == XW'(XDIM - 1));
    assign last_px = x_end && (yc == YW'(YDIM - 1));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state          <= IDLE;
            xc             <= '0;
            yc             <= '0;
            head_x_q       <= '0;
            head_y_q       <= '0;
            head_colour_q  <= '0;
            tail_x_q       <= '0;
            tail_y_q       <= '0;
            apple_x_q      <= '0;
            apple_y_q      <= '0;
            apple_colour_q <= '0;
            do_apple       <= 1'b0;
            apple_pending  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                head_x_q       <= head_x;
                head_y_q       <= head_y;
                head_colour_q  <= head_colour;
                tail_x_q       <= tail_x;
                tail_y_q       <= tail_y;
                apple_x_q      <= apple_x;
                apple_y_q      <= apple_y;
                apple_colour_q <= apple_colour;
                do_apple       <= apple_pending;
                xc             <= '0;
                yc             <= '0;
            end else if (drawing) begin
                if (x_end) begin
                    xc <= '0;
                    yc <= last_px ? '0 : yc + YW'(1);
                end else begin
                    xc <= xc + XW'(1);
                end
            end
            // A request landing on the final apple pixel must survive the clear.
            if (apple_req)
                apple_pending <= 1'b1;
            else if ((state == APPLE) && last_px)
                apple_pending <= 1'b0;
        end
    end

    // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = tail_valid ? ERASE : HEAD;
            ERASE:   if (last_px) state_nx = HEAD;
            HEAD:    if (last_px) state_nx = do_apple ? APPLE : DONE;
            APPLE:   if (last_px) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        base_x = '0;
        base_y = '0;
        colour = '0;
        case (state)
            ERASE: begin base_x = tail_x_q;  base_y = tail_y_q;  colour = BG_COLOUR;      end
            HEAD:  begin base_x = head_x_q;  base_y = head_y_q;  colour = head_colour_q;  end
            APPLE: begin base_x = apple_x_q; base_y = apple_y_q; colour = apple_colour_q; end
            default: ;
        endcase
    end

    // Clip test uses the untruncated sums so a block straddling the edge is cut, not wrapped.
    assign sum_x = {1'b0, base_x} + 9'(xc);
    assign sum_y = {1'b0, base_y} + 8'(yc);

    assign vga.vga_x      = drawing ? sum_x[7:0] : '0;
    assign vga.vga_y      = drawing ? sum_y[6:0] : '0;
    assign vga.vga_colour = drawing ? colour : '0;
    assign vga.plot       = drawing && (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

endmodule

// File: tb/tb_snake_draw_sequencer.sv
// Bench for snake_draw_sequencer: a frame-level pixel-list model checked every cycle,
// plus directed frames with hand-computed counts, timings and corner pixels.
`timescale 1ns/1ps
module tb_snake_draw_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b1;
    logic       tick = 1'b0, tail_valid = 1'b0, apple_req = 1'b0;
    logic [7:0] head_x = '0, tail_x = '0, apple_x = '0;
    logic [6:0] head_y = '0, tail_y = '0, apple_y = '0;
    logic [2:0] head_colour = '0, apple_colour = '0;
    logic       busy, done, apple_pending;

    int n_tests = 0;
    int n_fail  = 0;

    snake_draw_sequencer_if vga_if ();

    snake_draw_sequencer dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .tick         (tick),
        .head_x       (head_x),
        .head_y       (head_y),
        .head_colour  (head_colour),
        .tail_x       (tail_x),
        .tail_y       (tail_y),
        .tail_valid   (tail_valid),
        .apple_req    (apple_req),
        .apple_x      (apple_x),
        .apple_y      (apple_y),
        .apple_colour (apple_colour),
        .vga          (vga_if),
        .busy         (busy),
        .done         (done),
        .apple_pending(apple_pending)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each accepted tick expands into the list of per-cycle outputs of the frame.
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
        logic       d;
        logic       clr;
    } ent_t;

    ent_t q[$];
    logic m_pend = 1'b0;

    function automatic void add_block(input int bx, input int by, input logic [2:0] col,
                                      input logic is_apple);
        ent_t e;
        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 10; xx++) begin
                e.x   = 8'(bx + xx);
                e.y   = 7'(by + yy);
                e.c   = col;
                e.p   = ((bx + xx) < 160) && ((by + yy) < 120);
                e.d   = 1'b0;
                e.clr = is_apple && (xx == 9) && (yy == 9);
                q.push_back(e);
            end
    endfunction

    always @(posedge CLOCK_50 or negedge Resetn) begin
        logic clr;
        ent_t e;
        if (!Resetn) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            clr = (q.size() > 0) ? q[0].clr : 1'b0;
            if (q.size() > 0) begin
                void'(q.pop_front());
            end else if (tick) begin
                if (tail_valid) add_block(int'(tail_x), int'(tail_y), 3'b000, 1'b0);
                add_block(int'(head_x), int'(head_y), head_colour, 1'b0);
                if (m_pend) add_block(int'(apple_x), int'(apple_y), apple_colour, 1'b1);
                e = '{x: '0, y: '0, c: '0, p: 1'b0, d: 1'b1, clr: 1'b0};
                q.push_back(e);
            end
            m_pend = apple_req | (m_pend & ~clr);
        end
    end

    always @(negedge CLOCK_50) begin
        logic [21:0] a, e;
        a = {vga_if.vga_x, vga_if.vga_y, vga_if.vga_colour, vga_if.plot, busy, done, apple_pending};
        if (!Resetn)
            e = '0;
        else if (q.size() > 0)
            e = {q[0].x, q[0].y, q[0].c, q[0].p, 1'b1, q[0].d, m_pend};
        else
            e = {21'd0, m_pend};
        check("cycle_outputs", 32'(a), 32'(e));
    end

    task automatic set_inputs(input logic [7:0] hx, input logic [6:0] hy, input logic [2:0] hc,
                              input logic tv, input logic [7:0] tx, input logic [6:0] ty,
                              input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ac);
        head_x = hx; head_y = hy; head_colour = hc;
        tail_valid = tv; tail_x = tx; tail_y = ty;
        apple_x = ax; apple_y = ay; apple_colour = ac;
    endtask

    task automatic pulse_apple();
        @(posedge CLOCK_50); #1 apple_req = 1'b1;
        @(posedge CLOCK_50); #1 apple_req = 1'b0;
    endtask

    // Ticks once; k counts cycles after the accepting edge. Returns when IDLE follows done.
    task automatic run_frame(input int req_k, output int cyc, output int plots, output int busy_n,
                             output logic [14:0] first_xy, output logic [14:0] last_xy);
        logic got = 1'b0;
        cyc = 0; plots = 0; busy_n = 0; first_xy = '0; last_xy = '0;
        @(posedge CLOCK_50); #1 tick = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge CLOCK_50);
            apple_req = (k == req_k);
            if (vga_if.plot) begin
                if (!got) first_xy = {vga_if.vga_x, vga_if.vga_y};
                got     = 1'b1;
                last_xy = {vga_if.vga_x, vga_if.vga_y};
                plots++;
            end
            if (busy) busy_n++;
            if (done) begin
                cyc = k;
                break;
            end
        end
        @(negedge CLOCK_50);
        apple_req = 1'b0;
        check("busy_after_done", 32'(busy), 32'(0));
    endtask

    initial begin
        int cyc, plots, busy_n, d1, d2, k;
        logic idle_busy;
        logic [14:0] fxy, lxy;

        #1 Resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 check("reset_outputs",
                 32'({vga_if.vga_x, vga_if.vga_y, vga_if.vga_colour, vga_if.plot, busy, done, apple_pending}),
                 32'(0));
        @(posedge CLOCK_50); #1 Resetn = 1'b1;

        // Head only at (40,50).
        set_inputs(8'd40, 7'd50, 3'b010, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b000);
        run_frame(0, cyc, plots, busy_n, fxy, lxy);
        check("a_done_cycle", 32'(cyc), 32'd101);
        check("a_plots", 32'(plots), 32'd100);
        check("a_busy_cycles", 32'(busy_n), 32'd101);
        check("a_first_px", 32'(fxy), 32'({8'd40, 7'd50}));
        check("a_last_px", 32'(lxy), 32'({8'd49, 7'd59}));

        // Erase, head, apple.
        pulse_apple();
        set_inputs(8'd40, 7'd50, 3'b010, 1'b1, 8'd30, 7'd50, 8'd80, 7'd60, 3'b100);
        run_frame(0, cyc, plots, busy_n, fxy, lxy);
        check("b_done_cycle", 32'(cyc), 32'd301);
        check("b_plots", 32'(plots), 32'd300);
        check("b_first_px", 32'(fxy), 32'({8'd30, 7'd50}));
        check("b_last_px", 32'(lxy), 32'({8'd89, 7'd69}));
        check("b_pending_cleared", 32'(apple_pending), 32'd0);

        // Clipping at the bottom-right corner.
        set_inputs(8'd155, 7'd115, 3'b011, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b000);
        run_frame(0, cyc, plots, busy_n, fxy, lxy);
        check("clip_done_cycle", 32'(cyc), 32'd101);
        check("clip_plots", 32'(plots), 32'd25);
        check("clip_last_px", 32'(lxy), 32'({8'd159, 7'd119}));

        // apple_req mid-HEAD is not drawn this frame.
        set_inputs(8'd10, 7'd10, 3'b001, 1'b0, 8'd0, 7'd0, 8'd100, 7'd100, 3'b110);
        run_frame(50, cyc, plots, busy_n, fxy, lxy);
        check("c_done_cycle", 32'(cyc), 32'd101);
        check("c_pending_kept", 32'(apple_pending), 32'd1);

        // Apple drawn; a request on the last apple pixel keeps the flag set.
        set_inputs(8'd0, 7'd0, 3'b111, 1'b0, 8'd0, 7'd0, 8'd100, 7'd100, 3'b110);
        run_frame(200, cyc, plots, busy_n, fxy, lxy);
        check("d_done_cycle", 32'(cyc), 32'd201);
        check("d_last_px", 32'(lxy), 32'({8'd109, 7'd109}));
        check("d_set_wins", 32'(apple_pending), 32'd1);

        run_frame(0, cyc, plots, busy_n, fxy, lxy);
        check("e_done_cycle", 32'(cyc), 32'd201);
        check("e_pending_cleared", 32'(apple_pending), 32'd0);

        // tick held high: one frame, one IDLE cycle, then the next frame.
        set_inputs(8'd70, 7'd70, 3'b101, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b000);
        d1 = 0; d2 = 0; idle_busy = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b1;
        @(posedge CLOCK_50);
        for (int i = 1; i <= 1000; i++) begin
            @(negedge CLOCK_50);
            if (i == 102) idle_busy = busy;
            if (done) begin
                if (d1 == 0) d1 = i;
                else begin
                    d2 = i;
                    tick = 1'b0;
                    break;
                end
            end
        end
        check("held_first_done", 32'(d1), 32'd101);
        check("held_idle_gap", 32'(idle_busy), 32'd0);
        check("held_second_done", 32'(d2), 32'd203);
        @(negedge CLOCK_50);
        check("held_no_third", 32'(busy), 32'd0);

        // Reset during HEAD pixel 37 of an erase+head(+apple) frame.
        pulse_apple();
        set_inputs(8'd30, 7'd20, 3'b001, 1'b1, 8'd20, 7'd20, 8'd0, 7'd0, 3'b010);
        @(posedge CLOCK_50); #1 tick = 1'b1;
        @(posedge CLOCK_50); #1 tick = 1'b0;
        k = 0;
        while (k < 137) begin
            @(negedge CLOCK_50);
            k++;
        end
        @(posedge CLOCK_50);
        #1 check("pre_reset_plot", 32'({vga_if.vga_x, vga_if.plot}), 32'({8'd37, 1'b1}));
        #1 Resetn = 1'b0;
        #1 check("abort_outputs", 32'({vga_if.plot, busy, done, apple_pending}), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #3 Resetn = 1'b1;
        set_inputs(8'd60, 7'd30, 3'b011, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'b000);
        run_frame(0, cyc, plots, busy_n, fxy, lxy);
        check("post_reset_done", 32'(cyc), 32'd101);
        check("post_reset_first_px", 32'(fxy), 32'({8'd60, 7'd30}));
        check("post_reset_plots", 32'(plots), 32'd100);

        repeat (2) @(posedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
